load_scoreboard: RTL and testbench

Register scoreboard for the RV32I pipeline's variable-latency load path. It tracks every architectural register whose value is still owed by an outstanding load. The EX/MEM/WB forwarding network cannot supply that data until memory responds, so the block stalls the ID stage until the value is available. It sits beside the ID/EX pipeline register: ID presents decoded sources and destinations, and the memory writeback port retires loads.

---
 rtl/load_scoreboard.sv | 98 +++++++++
 tb/tb_load_scoreboard.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_scoreboard.sv
// Register scoreboard for the variable-latency load path: tracks registers owed by loads and stalls ID on hazards.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback satisfy source/WAW checks.
module load_scoreboard #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_regwrite,
    input  logic        id_is_load,
    input  logic        wb_load_valid,
    input  logic [4:0]  wb_load_rd,
    output logic        stall,
    output logic [31:0] pending,
    output logic [3:0]  outstanding,
    output logic        sb_error
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    logic [31:0] r_pending;
    logic [3:0]  r_outstanding;
    logic        r_error;

    logic [31:0] w_clr;
    logic [31:0] w_busy;
    logic [31:0] w_pending_nxt;
    logic        w_rs1_haz;
    logic        w_rs2_haz;
    logic        w_waw_haz;
    logic        w_cap_haz;
    logic        w_retire_ok;
    logic        w_retire_err;
    logic        w_issue;

    always_comb begin
        w_clr = '0;
        if (wb_load_valid && (wb_load_rd != 5'd0))
            w_clr[wb_load_rd] = 1'b1;
    end

    // With the bypass, a register being written back this cycle reads fresh from the write-first regfile.
`ifdef SCOREBOARD_WB_BYPASS_EN
    assign w_busy = r_pending & ~w_clr;
`else
    assign w_busy = r_pending;
`endif

    // A retire is honoured only if it is consistent with the tracked state; anything else is a protocol error.
    assign w_retire_ok  = wb_load_valid && (wb_load_rd != 5'd0) && r_pending[wb_load_rd]
                          && (r_outstanding != 4'd0);
    assign w_retire_err = wb_load_valid && !w_retire_ok;

    assign w_rs1_haz = id_use_rs1 && (id_rs1 != 5'd0) && w_busy[id_rs1];
    assign w_rs2_haz = id_use_rs2 && (id_rs2 != 5'd0) && w_busy[id_rs2];
    assign w_waw_haz = id_regwrite && (id_rd != 5'd0) && w_busy[id_rd];
    assign w_cap_haz = id_is_load && (r_outstanding == MAX_CNT) && !w_retire_ok;

    assign stall   = id_valid && (w_rs1_haz || w_rs2_haz || w_waw_haz || w_cap_haz);
    assign w_issue = id_valid && !stall && id_is_load && id_regwrite && (id_rd != 5'd0);

    // Set is applied after clear so a same-register issue and retire leaves the bit owed.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_retire_ok)
            w_pending_nxt[wb_load_rd] = 1'b0;
        if (w_issue)
            w_pending_nxt[id_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_error       <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            case ({w_issue, w_retire_ok})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_retire_err)
                r_error <= 1'b1;
        end
    end

    assign pending     = r_pending;
    assign outstanding = r_outstanding;
    assign sb_error    = r_error;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed self-checking bench for load_scoreboard (default MAX_OUTSTANDING = 4).
module tb_load_scoreboard;

    logic        clk = 1'b0;
    logic        rstN;
    logic        idValid, idUseRs1, idUseRs2, idRegwrite, idIsLoad, wbValid;
    logic [4:0]  idRs1, idRs2, idRd, wbRd;
    logic        stall, sbError;
    logic [31:0] pending;
    logic [3:0]  outstanding;

    int compCount = 0;
    int errCount  = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    load_scoreboard #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rstN),
        .id_valid(idValid), .id_rs1(idRs1), .id_rs2(idRs2),
        .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2),
        .id_rd(idRd), .id_regwrite(idRegwrite), .id_is_load(idIsLoad),
        .wb_load_valid(wbValid), .wb_load_rd(wbRd),
        .stall(stall), .pending(pending), .outstanding(outstanding), .sb_error(sbError)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clearInputs();
        idValid = 0; idUseRs1 = 0; idUseRs2 = 0; idRegwrite = 0; idIsLoad = 0;
        idRs1 = 0; idRs2 = 0; idRd = 0; wbValid = 0; wbRd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic presentLoad(input logic [4:0] rd);
        idValid = 1; idIsLoad = 1; idRegwrite = 1; idRd = rd;
        idUseRs1 = 0; idUseRs2 = 0;
    endtask

    task automatic test_reset();
        rstN = 0;
        clearInputs();
        #12;
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL reset_pending: got %h expected %h", pending, 32'h0); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
        compCount++; if (sbError !== 1'b0) begin errCount++; $display("[TB] FAIL reset_error: got %b expected 0", sbError); end
        compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
        rstN = 1;
        tick();
    endtask

    task automatic test_load_use();
        clearInputs();
        presentLoad(5'd5);
        #1;
        compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu_issue_stall: got %b expected 0", stall); end
        tick();
        compCount++; if (pending !== 32'h0000_0020) begin errCount++; $display("[TB] FAIL lu_pending: got %h expected %h", pending, 32'h20); end
        compCount++; if (outstanding !== 4'd1) begin errCount++; $display("[TB] FAIL lu_outstanding: got %0d expected 1", outstanding); end
        // add x6, x5, x1
        idIsLoad = 0; idRd = 5'd6; idUseRs1 = 1; idRs1 = 5'd5; idUseRs2 = 1; idRs2 = 5'd1;
        #1;
        compCount++; if (stall !== 1'b1) begin errCount++; $display("[TB] FAIL lu_use_stall: got %b expected 1", stall); end
        tick();
        compCount++; if (stall !== 1'b1) begin errCount++; $display("[TB] FAIL lu_hold_stall: got %b expected 1", stall); end
        compCount++; if (pending !== 32'h0000_0020) begin errCount++; $display("[TB] FAIL lu_hold_pending: got %h expected %h", pending, 32'h20); end
        wbValid = 1; wbRd = 5'd5;
        #1;
        compCount++; if (stall !== !BYPASS) begin errCount++; $display("[TB] FAIL lu_retire_stall: got %b expected %b", stall, !BYPASS); end
        tick();
        wbValid = 0; wbRd = 0;
        #1;
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL lu_after_pending: got %h expected 0", pending); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL lu_after_outstanding: got %0d expected 0", outstanding); end
        compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL lu_after_stall: got %b expected 0", stall); end
        tick();
        clearInputs();
    endtask

    task automatic test_x0();
        clearInputs();
        presentLoad(5'd0);
        #1;
        compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL x0_load_stall: got %b expected 0", stall); end
        tick();
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL x0_pending: got %h expected 0", pending); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL x0_outstanding: got %0d expected 0", outstanding); end
        idIsLoad = 0; idRd = 5'd8; idUseRs1 = 1; idRs1 = 5'd0; idUseRs2 = 1; idRs2 = 5'd0;
        #1;
        compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL x0_use_stall: got %b expected 0", stall); end
        tick();
        compCount++; if (sbError !== 1'b0) begin errCount++; $display("[TB] FAIL x0_error: got %b expected 0", sbError); end
        clearInputs();
    endtask

    task automatic test_capacity();
        logic [4:0] cleanup [4];
        cleanup = '{5'd1, 5'd3, 5'd4, 5'd7};
        clearInputs();
        for (int i = 1; i <= 4; i++) begin
            presentLoad(5'(i));
            #1;
            compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL cap_fill_stall_%0d: got %b expected 0", i, stall); end
            tick();
        end
        compCount++; if (outstanding !== 4'd4) begin errCount++; $display("[TB] FAIL cap_outstanding: got %0d expected 4", outstanding); end
        compCount++; if (pending !== 32'h0000_001E) begin errCount++; $display("[TB] FAIL cap_pending: got %h expected %h", pending, 32'h1E); end
        presentLoad(5'd7);
        #1;
        compCount++; if (stall !== 1'b1) begin errCount++; $display("[TB] FAIL cap_full_stall: got %b expected 1", stall); end
        wbValid = 1; wbRd = 5'd2;
        #1;
        compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL cap_retire_stall: got %b expected 0", stall); end
        tick();
        clearInputs();
        #1;
        compCount++; if (outstanding !== 4'd4) begin errCount++; $display("[TB] FAIL cap_swap_outstanding: got %0d expected 4", outstanding); end
        compCount++; if (pending !== 32'h0000_009A) begin errCount++; $display("[TB] FAIL cap_swap_pending: got %h expected %h", pending, 32'h9A); end
        for (int i = 0; i < 4; i++) begin
            wbValid = 1; wbRd = cleanup[i];
            tick();
        end
        clearInputs();
        #1;
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL cap_drain_outstanding: got %0d expected 0", outstanding); end
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL cap_drain_pending: got %h expected 0", pending); end
        compCount++; if (sbError !== 1'b0) begin errCount++; $display("[TB] FAIL cap_drain_error: got %b expected 0", sbError); end
    endtask

    task automatic test_same_reg();
        clearInputs();
        presentLoad(5'd9);
        tick();
        compCount++; if (pending !== 32'h0000_0200) begin errCount++; $display("[TB] FAIL same_setup_pending: got %h expected %h", pending, 32'h200); end
        wbValid = 1; wbRd = 5'd9;
        #1;
        compCount++; if (stall !== !BYPASS) begin errCount++; $display("[TB] FAIL same_stall: got %b expected %b", stall, !BYPASS); end
        tick();
        wbValid = 0; wbRd = 0;
        #1;
        if (BYPASS) begin
            compCount++; if (pending !== 32'h0000_0200) begin errCount++; $display("[TB] FAIL same_pending: got %h expected %h", pending, 32'h200); end
            compCount++; if (outstanding !== 4'd1) begin errCount++; $display("[TB] FAIL same_outstanding: got %0d expected 1", outstanding); end
        end else begin
            compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL same_nb_pending: got %h expected 0", pending); end
            compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL same_nb_outstanding: got %0d expected 0", outstanding); end
            compCount++; if (stall !== 1'b0) begin errCount++; $display("[TB] FAIL same_nb_stall: got %b expected 0", stall); end
            tick();
            compCount++; if (pending !== 32'h0000_0200) begin errCount++; $display("[TB] FAIL same_nb_reissue: got %h expected %h", pending, 32'h200); end
        end
        clearInputs();
        wbValid = 1; wbRd = 5'd9;
        tick();
        clearInputs();
        #1;
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL same_clean_pending: got %h expected 0", pending); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL same_clean_outstanding: got %0d expected 0", outstanding); end
        compCount++; if (sbError !== 1'b0) begin errCount++; $display("[TB] FAIL same_clean_error: got %b expected 0", sbError); end
    endtask

    task automatic test_error();
        clearInputs();
        presentLoad(5'd3);
        tick();
        clearInputs();
        wbValid = 1; wbRd = 5'd12;
        tick();
        clearInputs();
        #1;
        compCount++; if (sbError !== 1'b1) begin errCount++; $display("[TB] FAIL err_set: got %b expected 1", sbError); end
        compCount++; if (pending !== 32'h0000_0008) begin errCount++; $display("[TB] FAIL err_pending: got %h expected %h", pending, 32'h8); end
        compCount++; if (outstanding !== 4'd1) begin errCount++; $display("[TB] FAIL err_outstanding: got %0d expected 1", outstanding); end
        tick();
        compCount++; if (sbError !== 1'b1) begin errCount++; $display("[TB] FAIL err_sticky: got %b expected 1", sbError); end
        wbValid = 1; wbRd = 5'd3;
        tick();
        clearInputs();
        #1;
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL err_clean_pending: got %h expected 0", pending); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL err_clean_outstanding: got %0d expected 0", outstanding); end
    endtask

    task automatic test_async_reset();
        clearInputs();
        presentLoad(5'd10); tick();
        presentLoad(5'd11); tick();
        presentLoad(5'd13); tick();
        clearInputs();
        #1;
        compCount++; if (pending !== 32'h0000_2C00) begin errCount++; $display("[TB] FAIL ar_pre_pending: got %h expected %h", pending, 32'h2C00); end
        compCount++; if (outstanding !== 4'd3) begin errCount++; $display("[TB] FAIL ar_pre_outstanding: got %0d expected 3", outstanding); end
        #1;
        rstN = 0;
        #1;
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL ar_pending: got %h expected 0", pending); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL ar_outstanding: got %0d expected 0", outstanding); end
        compCount++; if (sbError !== 1'b0) begin errCount++; $display("[TB] FAIL ar_error: got %b expected 0", sbError); end
        #2;
        rstN = 1;
        tick();
        wbValid = 1; wbRd = 5'd10;
        tick();
        clearInputs();
        #1;
        compCount++; if (sbError !== 1'b1) begin errCount++; $display("[TB] FAIL ar_late_error: got %b expected 1", sbError); end
        compCount++; if (outstanding !== 4'd0) begin errCount++; $display("[TB] FAIL ar_late_outstanding: got %0d expected 0", outstanding); end
        compCount++; if (pending !== 32'h0) begin errCount++; $display("[TB] FAIL ar_late_pending: got %h expected 0", pending); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_capacity();
        test_same_reg();
        test_error();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
